// File: rtl/nibble_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : nibble_frame_loader
// Brief    : Serial-to-parallel front end for the 13-nibble Fibonacci majority
//            detector. Accepts one nibble per beat on a valid/ready stream,
//            frames each group of NIBS nibbles on a start-of-frame marker and
//            holds the assembled word on a valid/ready output until taken.
//            Flags early-SOF and missing-SOF framing errors; supports a
//            synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_frame_loader #(
    parameter int NIB_W = 4,   // width of one nibble
    parameter int NIBS  = 13,  // nibbles per frame
    parameter int CNT_W = 4    // beat counter width, 2**CNT_W > NIBS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic                  in_sof,
    input  logic [NIB_W-1:0]      in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NIB_W*NIBS-1:0] out_frame,
    output logic                  frame_err,
    output logic [CNT_W-1:0]      beat_cnt
);

    // ------------------------------------------------------------------------
    // Constants and state encoding
    // ------------------------------------------------------------------------
    localparam int               c_FRAME_W = NIB_W * NIBS;
    localparam logic [CNT_W-1:0] c_LAST    = CNT_W'(NIBS - 1);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,   // waiting for a start-of-frame beat
        S_FILL = 2'd1,   // collecting nibbles 1..NIBS-1
        S_FULL = 2'd2    // frame complete, waiting for the consumer
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------------
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_beat_cnt;
    logic [CNT_W-1:0]       w_beat_cnt_nxt;
    logic [c_FRAME_W-1:0]   r_frame;
    logic [c_FRAME_W-1:0]   w_frame_nxt;
    logic                   r_err;
    logic                   w_err_nxt;

    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_consume;

    // Handshake qualifiers. The loader stalls the input only while holding a
    // complete frame; the consume cycle itself accepts no input, which costs
    // one bubble between back-to-back frames.
    assign w_in_ready = (r_state != S_FULL);
    assign w_accept   = in_valid & w_in_ready;
    assign w_consume  = (r_state == S_FULL) & out_ready;

    // State, counter, frame and error registers; async reset to an empty IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_beat_cnt <= '0;
            r_frame    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_frame    <= w_frame_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // Next-state, slot write and framing-error decode; flush overrides all
    always_comb begin
        w_state_nxt    = r_state;
        w_beat_cnt_nxt = r_beat_cnt;
        w_frame_nxt    = r_frame;
        w_err_nxt      = 1'b0;

        if (flush) begin
            // Discard everything, including a beat offered this cycle.
            w_state_nxt    = S_IDLE;
            w_beat_cnt_nxt = '0;
            w_frame_nxt    = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (in_sof) begin
                            // Slots are already zero here (cleared on
                            // consume/flush/reset); clearing again keeps the
                            // frame free of stale data regardless of history.
                            w_frame_nxt              = '0;
                            w_frame_nxt[NIB_W-1:0]   = in_data;
                            w_beat_cnt_nxt           = c_ONE;
                            w_state_nxt              = S_FILL;
                        end else begin
                            // Nibble without a frame start: drop and flag.
                            w_err_nxt = 1'b1;
                        end
                    end
                end

                S_FILL: begin
                    if (w_accept) begin
                        if (in_sof) begin
                            // Early SOF: restart the frame with this nibble
                            // as slot 0 so no partial data leaks into it.
                            w_err_nxt                = 1'b1;
                            w_frame_nxt              = '0;
                            w_frame_nxt[NIB_W-1:0]   = in_data;
                            w_beat_cnt_nxt           = c_ONE;
                        end else begin
                            // Write only the addressed slot.
                            for (int k = 0; k < NIBS; k++) begin
                                if (r_beat_cnt == CNT_W'(k)) begin
                                    w_frame_nxt[k*NIB_W +: NIB_W] = in_data;
                                end
                            end
                            if (r_beat_cnt == c_LAST) begin
                                w_beat_cnt_nxt = '0;
                                w_state_nxt    = S_FULL;
                            end else begin
                                w_beat_cnt_nxt = r_beat_cnt + c_ONE;
                            end
                        end
                    end
                end

                S_FULL: begin
                    // Frame is held stable until the consumer takes it.
                    if (w_consume) begin
                        w_frame_nxt = '0;
                        w_state_nxt = S_IDLE;
                    end
                end

                default: begin
                    w_state_nxt    = S_IDLE;
                    w_beat_cnt_nxt = '0;
                    w_frame_nxt    = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready  = w_in_ready;
    assign out_valid = (r_state == S_FULL);
    assign out_frame = r_frame;
    assign frame_err = r_err;
    assign beat_cnt  = r_beat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_nibble_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_frame_loader
// Brief    : Self-checking bench for nibble_frame_loader: directed scenarios
//            followed by randomized traffic, compared every cycle against a
//            queue-based frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_frame_loader;

    localparam int c_NIB_W = 4;
    localparam int c_NIBS  = 13;
    localparam int c_CNT_W = 4;
    localparam int c_FW    = c_NIB_W * c_NIBS;

    logic               clk;
    logic               rst_n;
    logic               flush;
    logic               in_valid;
    logic               in_sof;
    logic [c_NIB_W-1:0] in_data;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic [c_FW-1:0]    out_frame;
    logic               frame_err;
    logic [c_CNT_W-1:0] beat_cnt;

    nibble_frame_loader #(
        .NIB_W (c_NIB_W),
        .NIBS  (c_NIBS),
        .CNT_W (c_CNT_W)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_frame (out_frame),
        .frame_err (frame_err),
        .beat_cnt  (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: nibbles of the partial frame, plus the held frame
    logic [c_NIB_W-1:0] m_q[$];
    bit                 m_full;
    logic [c_FW-1:0]    m_frame;
    bit                 m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [c_FW-1:0] exp_frame();
        logic [c_FW-1:0] r;
        if (m_full) return m_frame;
        r = '0;
        foreach (m_q[k]) r[k*c_NIB_W +: c_NIB_W] = m_q[k];
        return r;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_full  = 1'b0;
        m_frame = '0;
        m_err   = 1'b0;
    endtask

    task automatic model_step(input bit f, input bit v, input bit s,
                              input logic [c_NIB_W-1:0] d, input bit o);
        m_err = 1'b0;
        if (f) begin
            model_reset();
        end else if (m_full) begin
            if (o) begin
                m_full  = 1'b0;
                m_frame = '0;
            end
        end else if (v) begin
            if (s) begin
                m_err = (m_q.size() != 0);
                m_q.delete();
                m_q.push_back(d);
            end else if (m_q.size() == 0) begin
                m_err = 1'b1;
            end else begin
                m_q.push_back(d);
            end
            if (m_q.size() == c_NIBS) begin
                m_frame = exp_frame();
                m_full  = 1'b1;
                m_q.delete();
            end
        end
    endtask

    task automatic compare_all();
        chk("out_valid", 64'(out_valid), 64'(m_full));
        chk("in_ready",  64'(in_ready),  64'(!m_full));
        chk("beat_cnt",  64'(beat_cnt),  m_full ? 64'd0 : 64'(m_q.size()));
        chk("frame_err", 64'(frame_err), 64'(m_err));
        chk("out_frame", 64'(out_frame), 64'(exp_frame()));
    endtask

    // One clock: drive inputs, advance the model at the edge, check after it
    task automatic cycle(input bit f, input bit v, input bit s,
                         input logic [c_NIB_W-1:0] d, input bit o);
        flush     = f;
        in_valid  = v;
        in_sof    = s;
        in_data   = d;
        out_ready = o;
        @(posedge clk);
        model_step(f, v, s, d, o);
        #1;
        compare_all();
    endtask

    task automatic send_frame(input bit o);
        for (int k = 0; k < c_NIBS; k++)
            cycle(1'b0, 1'b1, (k == 0), 4'($urandom_range(0, 15)), o);
    endtask

    initial begin
        logic [c_NIB_W-1:0] fib[c_NIBS] = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd13, 4'd0,
                                             4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd13};
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
        in_data = '0; out_ready = 1'b0;
        model_reset();

        // Reset values before any clock edge
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_beat_cnt",  64'(beat_cnt),  64'd0);
        chk("rst_frame",     64'(out_frame), 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Fibonacci frame with consumer always ready
        for (int k = 0; k < c_NIBS; k++)
            cycle(1'b0, 1'b1, (k == 0), fib[k], 1'b1);
        chk("fib_valid",  64'(out_valid),          64'd1);
        chk("fib_slot0",  64'(out_frame[3:0]),     64'd1);
        chk("fib_slot12", 64'(out_frame[51:48]),   64'd13);
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        chk("fib_ready_back", 64'(in_ready), 64'd1);

        // Held frame: consumer stalls 5 cycles while offers are refused
        send_frame(1'b0);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b1, 4'd9, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 4'd9, 1'b1);   // consume, beat not taken
        cycle(1'b0, 1'b1, 1'b1, 4'd6, 1'b0);   // SOF accepted next cycle
        chk("sof_after_consume", 64'(beat_cnt), 64'd1);
        for (int k = 1; k < c_NIBS; k++) cycle(1'b0, 1'b1, 1'b0, 4'(k), 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);

        // Missing SOF in IDLE
        cycle(1'b0, 1'b1, 1'b0, 4'd7, 1'b1);
        chk("nosof_err", 64'(frame_err), 64'd1);
        cycle(1'b0, 1'b0, 1'b1, 4'd3, 1'b1);   // sof without valid ignored

        // Early SOF after 6 beats, then complete cleanly
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1, (k == 0), 4'd15, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 4'd4, 1'b1);
        chk("early_sof_frame", 64'(out_frame), 64'd4);
        for (int k = 1; k < c_NIBS; k++) cycle(1'b0, 1'b1, 1'b0, 4'($urandom_range(0, 15)), 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);

        // Flush at beat 7 with a valid beat, then a clean frame
        for (int k = 0; k < 7; k++) cycle(1'b0, 1'b1, (k == 0), 4'($urandom_range(0, 15)), 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 4'd11, 1'b1);
        chk("flush_cnt", 64'(beat_cnt), 64'd0);
        send_frame(1'b1);
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);

        // Flush while holding a frame
        send_frame(1'b0);
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);

        // Asynchronous reset while a frame is held
        send_frame(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_out_frame", 64'(out_frame), 64'd0);
        chk("async_in_ready",  64'(in_ready),  64'd1);
        model_reset();
        #2;
        rst_n = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            cycle(($urandom_range(0, 99) < 2),
                  ($urandom_range(0, 99) < 85),
                  ($urandom_range(0, 99) < 6),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 99) < 60));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nibble_frame_loader.md
Name: nibble_frame_loader

Overview:
- Serial-to-parallel front end that sits directly upstream of the 13-nibble Fibonacci majority detector.
- Accepts one 4-bit nibble per beat on a valid/ready stream, frames each group of 13 using a start-of-frame marker, and presents the frame as a 52-bit parallel word.
- Holds the frame on a valid/ready output until the consumer takes it.
- Handles framing errors (early SOF, missing SOF) and a synchronous flush.

Parameters:
- NIB_W, 4, width of one nibble.
- NIBS, 13, nibbles per frame.
- CNT_W, 4, width of the beat counter; must satisfy 2^CNT_W > NIBS.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear; discards any partial or held frame.
- in_valid  input  1  input nibble valid.
- in_sof  input  1  qualifies in_data as nibble 0 of a frame; meaningful only when in_valid=1.
- in_data  input  NIB_W  input nibble.
- in_ready  output  1  loader can accept a nibble this cycle.
- out_valid  output  1  complete frame held on out_frame.
- out_ready  input  1  consumer accepts the frame.
- out_frame  output  NIB_W*NIBS  assembled frame; nibble k at bits [4k+3:4k], so nibble 0 drives inp1 of the detector and nibble 12 drives inp13.
- frame_err  output  1  one-cycle pulse on a framing error.
- beat_cnt  output  CNT_W  nibbles accepted in the current partial frame.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, beat_cnt=0, out_frame=0, out_valid=0, frame_err=0.
  - in_ready=1 (combinational from state).
- Handshakes:
  - A beat is accepted when in_valid & in_ready.
  - A frame is consumed when out_valid & out_ready.
  - out_frame and out_valid stay stable while out_valid=1 and out_ready=0.
- States:
  - IDLE, waiting for SOF, in_ready=1:
    - Accepted beat with in_sof=1: store nibble at slot 0, beat_cnt=1, go to FILL.
    - Accepted beat with in_sof=0: drop the nibble, pulse frame_err, stay in IDLE.
  - FILL, in_ready=1:
    - Accepted beat with in_sof=0: store at slot beat_cnt, increment beat_cnt.
    - When the stored nibble is slot NIBS-1: set out_valid=1, beat_cnt=0, go to FULL.
    - Accepted beat with in_sof=1 (early SOF): pulse frame_err, clear the partial frame (unwritten slots read 0), store the nibble at slot 0, beat_cnt=1, stay in FILL.
  - FULL, in_ready=0, out_valid=1:
    - On consume: out_valid=0 next cycle, go to IDLE.
    - No input is accepted in the consume cycle. Back-to-back frames therefore cost one bubble: a frame every NIBS+1 cycles at best.
- Latency:
  - The 13th nibble accepted at edge N gives out_valid=1 after edge N, with out_frame valid in the same cycle.
- Slot writes:
  - Only the addressed nibble slot changes. Other slots keep their values until the frame is consumed or cleared.
  - out_frame is cleared to 0 on consume. The detector sees 0 only while out_valid=0.
- flush:
  - Has priority over every other event.
  - Next state is IDLE, beat_cnt=0, out_valid=0, out_frame=0, frame_err=0.
  - A beat presented in the same cycle is not stored, even though in_ready may read 1.
- Reset mid-frame: same result as flush, applied immediately (async).
- beat_cnt never exceeds NIBS-1 and reads 0 in IDLE and FULL.
- in_sof while in_valid=0 is ignored.
- Data-path arithmetic: none; nibbles pass through unchanged (values 0–15). Fibonacci classification stays in the downstream detector.

Test Plan:
- Reset, then SOF with nibbles 1,2,3,5,8,13,0,1,2,3,5,8,13 on 13 consecutive cycles, out_ready=1 → out_valid high 1 cycle after the last beat; out_frame[3:0]=1, out_frame[51:48]=13; frame_err never pulses; in_ready is low for exactly 1 cycle.
- Full frame with out_ready held 0 for 5 cycles → out_valid and out_frame stable and in_ready=0 for all 5 cycles; consume on cycle 6; next SOF is accepted 1 cycle after the consume.
- IDLE: in_valid=1, in_sof=0, data=7 → frame_err pulses 1 cycle, beat_cnt stays 0, nothing is stored.
- SOF plus 5 nibbles, then a new SOF with data=4 → frame_err pulse, beat_cnt=1, slot 0=4, slots 1–12=0; completing 12 more beats gives exactly one frame with no stale data.
- flush asserted at beat 7 with in_valid=1 → beat not stored; IDLE, beat_cnt=0, out_valid=0; a following clean frame is assembled correctly.
- rst_n pulsed low mid-clock with out_valid=1 → out_valid=0 and out_frame=0 immediately (asynchronously), before the next edge.
